// File: rtl/fifo_wr_arb_if.sv
// Producer/FIFO-push bundle shared between the round-robin write arbiter and its environment.
// master: arbiter side (grants producers, drives the FIFO push port); slave: producers + FIFO.
interface fifo_wr_arb_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned TAG_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_en;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_push;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_data_in;
  logic                          fifo_clear;
  logic                          fifo_full;
  logic [CNT_WIDTH-1:0]          fifo_count;

  modport master (
    input  req_valid, req_data, req_en, fifo_full, fifo_count,
    output req_ready, fifo_push, fifo_data_in, fifo_clear
  );

  modport slave (
    output req_valid, req_data, req_en, fifo_full, fifo_count,
    input  req_ready, fifo_push, fifo_data_in, fifo_clear
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one eligible producer per cycle into a shared FIFO through a
// one-word output register, guarding against overflow and counting refused cycles.
module fifo_wr_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arb_clear,
  output logic [15:0]  wait_cnt,
  fifo_wr_arb_if.master bus
);
  localparam int unsigned TAG_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_WIDTH = TAG_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH:0] DEPTH_CMP = (CNT_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [TAG_WIDTH:0] NUM_CMP   = (TAG_WIDTH + 1)'(NUM_REQ);
  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]   elig;
  logic [CNT_WIDTH:0]   occ_next;
  logic                 space_ok;
  logic                 grant_found;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [TAG_WIDTH:0]   cand;
  logic                 accept;

  logic [TAG_WIDTH-1:0] rr_q, rr_d;
  logic                 push_q, push_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [15:0]          wait_q, wait_d;

  assign elig = bus.req_valid & bus.req_en;

  // Count the word already sitting in the output register as occupied.
  assign occ_next = {1'b0, bus.fifo_count} + {{CNT_WIDTH{1'b0}}, push_q};
  assign space_ok = ~bus.fifo_full & (occ_next < DEPTH_CMP);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (TAG_WIDTH + 1)'(k);
      if (cand >= NUM_CMP) begin
        cand = cand - NUM_CMP;
      end
      if (!grant_found && elig[cand[TAG_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[TAG_WIDTH-1:0];
      end
    end
  end

  assign accept = grant_found & space_ok & ~arb_clear & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_d   = rr_q;
    push_d = 1'b0;
    data_d = data_q;
    wait_d = wait_q;
    if (arb_clear) begin
      rr_d   = '0;
      data_d = '0;
      wait_d = '0;
    end else begin
      if (accept) begin
        push_d = 1'b1;
        data_d = {grant_idx, bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH]};
        rr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
      if ((|elig) && !space_ok && (wait_q != 16'hFFFF)) begin
        wait_d = wait_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= '0;
      push_q <= 1'b0;
      data_q <= '0;
      wait_q <= '0;
    end else begin
      rr_q   <= rr_d;
      push_q <= push_d;
      data_q <= data_d;
      wait_q <= wait_d;
    end
  end

  assign bus.fifo_push    = push_q;
  assign bus.fifo_data_in = data_q;
  assign bus.fifo_clear   = arb_clear;
  assign wait_cnt         = wait_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a small occupancy model of the attached 16-deep FIFO.
module tb_fifo_wr_arb;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arb_clear = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] wait_cnt;
  logic [4:0]  fcnt;
  int          n_assert = 0;
  int          n_fail = 0;
  int          pushes;

  fifo_wr_arb_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fifo_wr_arb #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .arb_clear(arb_clear),
    .wait_cnt (wait_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // FIFO occupancy: clear dominates a same-cycle push.
  always @(posedge clk or posedge rst) begin
    if (rst) fcnt <= '0;
    else if (bus.fifo_clear) fcnt <= '0;
    else fcnt <= fcnt + {4'b0, bus.fifo_push} - {4'b0, (pop && fcnt != 5'd0)};
  end
  assign bus.fifo_count = fcnt;
  assign bus.fifo_full  = (fcnt == 5'd16);

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101;
  endfunction

  function automatic logic [33:0] word(input int i);
    logic [1:0] t;
    t = 2'(i);
    return {t, dat(i)};
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_en    = '0;
    for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = dat(i);
    #2;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_push", bus.fifo_push, 0);
    chk("rst_data", bus.fifo_data_in, 0);
    chk("rst_wait", wait_cnt, 0);
    chk("rst_fclear", bus.fifo_clear, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // Round robin across all four requesters
    bus.req_valid = 4'hF;
    bus.req_en    = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", bus.req_ready, onehot(k % 4));
      if (k > 0) begin
        chk("rr_push", bus.fifo_push, 1);
        chk("rr_data", bus.fifo_data_in, word((k - 1) % 4));
      end
      cyc();
    end
    bus.req_valid = '0;
    #1;
    chk("rr_last_push", bus.fifo_push, 1);
    chk("rr_last_data", bus.fifo_data_in, word(3));
    chk("rr_idle_ready", bus.req_ready, 0);
    cyc();
    chk("rr_idle_push", bus.fifo_push, 0);
    chk("rr_hold_data", bus.fifo_data_in, word(3));

    // arb_clear during a stream
    bus.req_valid = 4'hF;
    #1;
    chk("clr_pre_ready", bus.req_ready, 4'b0001);
    cyc();
    chk("clr_pre_data", bus.fifo_data_in, word(0));
    arb_clear = 1'b1;
    #1;
    chk("clr_fclear", bus.fifo_clear, 1);
    chk("clr_ready", bus.req_ready, 0);
    chk("clr_push_reg", bus.fifo_push, 1);
    cyc();
    chk("clr_push", bus.fifo_push, 0);
    chk("clr_data", bus.fifo_data_in, 0);
    chk("clr_wait", wait_cnt, 0);
    arb_clear = 1'b0;
    #1;
    chk("clr_fclear_off", bus.fifo_clear, 0);
    chk("clr_rr0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    cyc();

    // Skip and wrap: requesters 1 and 3 only
    bus.req_valid = 4'b0010;
    #1;
    chk("skip_ready1", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = 4'b1010;
    #1;
    chk("skip_data1", bus.fifo_data_in, word(1));
    for (int j = 0; j < 4; j++) begin
      chk("skip_ready", bus.req_ready, onehot((j % 2 == 0) ? 3 : 1));
      cyc();
      chk("skip_data", bus.fifo_data_in, word((j % 2 == 0) ? 3 : 1));
    end
    bus.req_en = 4'b0111;
    #1;
    chk("dis_ready", bus.req_ready, 4'b0010);
    cyc();
    chk("dis_data", bus.fifo_data_in, word(1));
    chk("dis_ready2", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();
    arb_clear = 1'b1;
    cyc();
    arb_clear = 1'b0;

    // Full limit: no pops, exactly FIFO_DEPTH pushes
    bus.req_valid = 4'hF;
    bus.req_en    = 4'hF;
    pushes = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.fifo_push) pushes++;
      chk("no_push_full", bus.fifo_push & bus.fifo_full, 0);
    end
    chk("full_pushes", pushes, 16);
    chk("full_wait", wait_cnt, 14);
    chk("full_ready", bus.req_ready, 0);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("pop_wait", wait_cnt, 15);
    #1;
    chk("pop_ready", bus.req_ready, 4'b0001);
    cyc();
    chk("pop_push", bus.fifo_push, 1);
    chk("pop_data", bus.fifo_data_in, word(0));
    chk("pop_wait_hold", wait_cnt, 15);
    chk("pop_refull_ready", bus.req_ready, 0);
    cyc();
    chk("pop_refull_push", bus.fifo_push, 0);
    chk("pop_refull_wait", wait_cnt, 16);
    arb_clear = 1'b1;
    #1;
    chk("clr2_fclear", bus.fifo_clear, 1);
    chk("clr2_ready", bus.req_ready, 0);
    cyc();
    chk("clr2_wait", wait_cnt, 0);
    arb_clear = 1'b0;

    // Saturation: 16 accepts, then refused cycles only
    repeat (16 + 65534) cyc();
    chk("sat_fffe", wait_cnt, 16'hFFFE);
    cyc();
    chk("sat_ffff", wait_cnt, 16'hFFFF);
    repeat (4500) cyc();
    chk("sat_hold", wait_cnt, 16'hFFFF);

    // Reset mid-burst drops the pending push asynchronously
    arb_clear = 1'b1;
    cyc();
    arb_clear = 1'b0;
    #1;
    chk("mid_ready", bus.req_ready, 4'b0001);
    cyc();
    chk("mid_push", bus.fifo_push, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_push", bus.fifo_push, 0);
    chk("mid_rst_data", bus.fifo_data_in, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    chk("mid_rst_wait", wait_cnt, 0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
